// File: rtl/peb_frm_ctrl_if.sv
// rtl/peb_frm_ctrl_if.sv - psum SRAM drain bus between a PE bank and the pooling unit
interface peb_frm_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              POOL_Rdy;
    logic              POOLPEB_EnRd;
    logic [ADDR_W-1:0] POOLPEB_AddrRd;
    logic              PEBPOOL_VldDat;

    modport master (
        input  POOL_Rdy,
        output POOLPEB_EnRd,
        output POOLPEB_AddrRd,
        output PEBPOOL_VldDat
    );

    modport slave (
        output POOL_Rdy,
        input  POOLPEB_EnRd,
        input  POOLPEB_AddrRd,
        input  PEBPOOL_VldDat
    );
endinterface

// File: rtl/peb_frm_ctrl.sv
// rtl/peb_frm_ctrl.sv - PE bank frame/block sequencer with flow-controlled psum drain
module peb_frm_ctrl #(
    parameter int LENPSUM = 16,
    parameter int ADDR_W  = $clog2(LENPSUM),
    parameter int BLK_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             TOP_StartFrm,
    input  logic [BLK_W-1:0] CFG_NumBlk,
    input  logic             PEC_LstActBlk,
    output logic             CTRLPEB_FrtBlk,
    output logic             CTRLPEB_FnhFrm,
    output logic             CTRL_Idle,
    output logic             CTRL_Err,
    peb_frm_ctrl_if.master   pool
);
    typedef enum logic [2:0] {IDLE, FRT, RUN, WAIT, FNH} frm_state_t;
    typedef enum logic       {DIDLE, DRN} drn_state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(LENPSUM - 1);

    frm_state_t        frm_state, frm_next;
    drn_state_t        drn_state, drn_next;
    logic [BLK_W-1:0]  blk_cnt, num_blk;
    logic [ADDR_W-1:0] addr;
    logic              vld_dat, err;
    logic              drn_busy, last_blk, en_rd, in_blk;

    // Read data stays valid one cycle past the last enable, so the bank toggle must wait for it too.
    assign drn_busy = (drn_state == DRN) | vld_dat;
    assign last_blk = (blk_cnt == num_blk - BLK_W'(1));
    assign en_rd    = (drn_state == DRN) & pool.POOL_Rdy;
    assign in_blk   = (frm_state == FRT) | (frm_state == RUN);

    always_comb begin
        frm_next = frm_state;
        case (frm_state)
            IDLE: if (TOP_StartFrm) frm_next = FRT;
            FRT, RUN: begin
                if (PEC_LstActBlk) begin
                    if (last_blk) frm_next = drn_busy ? WAIT : FNH;
                    else          frm_next = RUN;
                end
            end
            WAIT: if (!drn_busy) frm_next = FNH;
            FNH:  frm_next = IDLE;
            default: frm_next = IDLE;
        endcase
    end

    always_comb begin
        drn_next = drn_state;
        case (drn_state)
            DIDLE: if (frm_state == FNH) drn_next = DRN;
            DRN:   if (en_rd && addr == ADDR_LAST) drn_next = DIDLE;
            default: drn_next = DIDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frm_state <= IDLE;
            drn_state <= DIDLE;
            blk_cnt   <= '0;
            num_blk   <= '0;
            addr      <= '0;
            vld_dat   <= 1'b0;
            err       <= 1'b0;
        end else begin
            frm_state <= frm_next;
            drn_state <= drn_next;
            vld_dat   <= en_rd;
            if (frm_state == IDLE && TOP_StartFrm) begin
                num_blk <= (CFG_NumBlk == '0) ? BLK_W'(1) : CFG_NumBlk;
                blk_cnt <= '0;
            end
            if (in_blk && PEC_LstActBlk && !last_blk)
                blk_cnt <= blk_cnt + BLK_W'(1);
            if (PEC_LstActBlk && !in_blk)
                err <= 1'b1;
            if (en_rd)
                addr <= (addr == ADDR_LAST) ? '0 : addr + ADDR_W'(1);
        end
    end

    assign CTRLPEB_FrtBlk      = (frm_state == FRT);
    assign CTRLPEB_FnhFrm      = (frm_state == FNH);
    assign CTRL_Idle           = (frm_state == IDLE);
    assign CTRL_Err            = err;
    assign pool.POOLPEB_EnRd   = en_rd;
    assign pool.POOLPEB_AddrRd = addr;
    assign pool.PEBPOOL_VldDat = vld_dat;
endmodule

// File: tb/tb_peb_frm_ctrl.sv
// tb/tb_peb_frm_ctrl.sv - directed self-checking bench for peb_frm_ctrl
module tb_peb_frm_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] cfg;
    logic       lst;
    logic       frt, fnh, idle, err;
    int         n_cmp = 0;
    int         n_err = 0;

    peb_frm_ctrl_if #(.ADDR_W(4)) pool ();

    peb_frm_ctrl #(.LENPSUM(16), .BLK_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .TOP_StartFrm   (start),
        .CFG_NumBlk     (cfg),
        .PEC_LstActBlk  (lst),
        .CTRLPEB_FrtBlk (frt),
        .CTRLPEB_FnhFrm (fnh),
        .CTRL_Idle      (idle),
        .CTRL_Err       (err),
        .pool           (pool.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int exp_addr;
        int exp_in;
        int en_cnt;
        int vld_cnt;
        int last_vld;
        int first_fnh;

        rst = 1'b1; start = 1'b0; cfg = 8'd0; lst = 1'b0; pool.POOL_Rdy = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_idle", idle, 1);
        chk("rst_frt", frt, 0);
        chk("rst_fnh", fnh, 0);
        chk("rst_enrd", pool.POOLPEB_EnRd, 0);
        chk("rst_vld", pool.PEBPOOL_VldDat, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", pool.POOLPEB_AddrRd, 0);

        // three-block frame, pool always ready
        pool.POOL_Rdy = 1'b1;
        cfg = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        chk("f1_frt_rise", frt, 1);
        chk("f1_idle_low", idle, 0);
        repeat (9) tick();
        chk("f1_frt_hold", frt, 1);
        lst = 1'b1; tick(); lst = 1'b0;
        chk("f1_frt_fall", frt, 0);
        repeat (4) tick();
        start = 1'b1; tick(); start = 1'b0;
        chk("f1_start_ignored_idle", idle, 0);
        chk("f1_start_ignored_frt", frt, 0);
        repeat (4) tick();
        lst = 1'b1; tick(); lst = 1'b0;
        chk("f1_no_fnh_blk2", fnh, 0);
        repeat (9) tick();
        lst = 1'b1; tick(); lst = 1'b0;
        chk("f1_fnh", fnh, 1);
        chk("f1_err", err, 0);
        tick();
        chk("f1_fnh_once", fnh, 0);
        chk("f1_idle_after", idle, 1);
        for (int i = 0; i < 16; i++) begin
            chk("f1_enrd", pool.POOLPEB_EnRd, 1);
            chk("f1_addr", pool.POOLPEB_AddrRd, i);
            chk("f1_vld", pool.PEBPOOL_VldDat, (i != 0) ? 1 : 0);
            tick();
        end
        chk("f1_enrd_end", pool.POOLPEB_EnRd, 0);
        chk("f1_vld_tail", pool.PEBPOOL_VldDat, 1);
        tick();
        chk("f1_vld_end", pool.PEBPOOL_VldDat, 0);
        chk("f1_addr_wrap", pool.POOLPEB_AddrRd, 0);

        // one-block frame, drain with Rdy toggling 1,0,1,0
        cfg = 8'd1; start = 1'b1; tick(); start = 1'b0;
        lst = 1'b1; tick(); lst = 1'b0;
        chk("f2_fnh", fnh, 1);
        tick();
        exp_addr = 0; exp_in = 1; en_cnt = 0; vld_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            pool.POOL_Rdy = (k % 2 == 0);
            #1;
            chk("f2_enrd", pool.POOLPEB_EnRd, (exp_in != 0 && pool.POOL_Rdy) ? 1 : 0);
            if (exp_in != 0) chk("f2_addr", pool.POOLPEB_AddrRd, exp_addr);
            if (pool.POOLPEB_EnRd) en_cnt++;
            if (pool.PEBPOOL_VldDat) vld_cnt++;
            if (exp_in != 0 && pool.POOL_Rdy) begin
                exp_addr++;
                if (exp_addr == 16) exp_in = 0;
            end
            tick();
        end
        chk("f2_en_cnt", en_cnt, 16);
        chk("f2_vld_cnt", vld_cnt, 16);
        chk("f2_addr_end", pool.POOLPEB_AddrRd, 0);

        // frame ends while previous drain is stalled at address 5
        pool.POOL_Rdy = 1'b1;
        cfg = 8'd1; start = 1'b1; tick(); start = 1'b0;
        lst = 1'b1; tick(); lst = 1'b0;
        chk("f3a_fnh", fnh, 1);
        start = 1'b1; tick(); start = 1'b0;
        chk("f3_start_in_fnh_ignored", idle, 1);
        chk("f3_addr0", pool.POOLPEB_AddrRd, 0);
        start = 1'b1; tick(); start = 1'b0;
        chk("f3b_frt", frt, 1);
        repeat (4) tick();
        chk("f3_addr5", pool.POOLPEB_AddrRd, 5);
        pool.POOL_Rdy = 1'b0;
        lst = 1'b1; tick(); lst = 1'b0;
        chk("f3_wait_fnh", fnh, 0);
        chk("f3_wait_addr", pool.POOLPEB_AddrRd, 5);
        chk("f3_wait_enrd", pool.POOLPEB_EnRd, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("f3_hold_fnh", fnh, 0);
            chk("f3_hold_idle", idle, 0);
        end
        pool.POOL_Rdy = 1'b1;
        last_vld = -1; first_fnh = -1;
        for (int k = 0; k < 30; k++) begin
            if (pool.PEBPOOL_VldDat && first_fnh < 0) last_vld = k;
            if (fnh && first_fnh < 0) first_fnh = k;
            tick();
        end
        chk("f3_last_vld", last_vld, 11);
        chk("f3_fnh_cycle", first_fnh, 13);
        chk("f3_fnh_gap", first_fnh - last_vld, 2);
        repeat (4) tick();
        chk("f3_drain_done", pool.PEBPOOL_VldDat, 0);

        // NumBlk = 0 behaves as 1
        cfg = 8'd0; start = 1'b1; tick(); start = 1'b0;
        chk("f4_frt", frt, 1);
        lst = 1'b1; tick(); lst = 1'b0;
        chk("f4_fnh", fnh, 1);
        repeat (20) tick();
        chk("f4_err", err, 0);

        // block end while idle is a sticky error
        lst = 1'b1; tick(); lst = 1'b0;
        chk("f5_err_set", err, 1);
        repeat (3) tick();
        chk("f5_err_sticky", err, 1);
        chk("f5_idle", idle, 1);

        // reset mid-drain
        cfg = 8'd1; start = 1'b1; tick(); start = 1'b0;
        lst = 1'b1; tick(); lst = 1'b0;
        tick();
        repeat (7) tick();
        chk("f6_addr7", pool.POOLPEB_AddrRd, 7);
        chk("f6_enrd_pre", pool.POOLPEB_EnRd, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("f6_enrd", pool.POOLPEB_EnRd, 0);
        chk("f6_vld", pool.PEBPOOL_VldDat, 0);
        chk("f6_idle", idle, 1);
        chk("f6_err", err, 0);
        chk("f6_fnh", fnh, 0);
        chk("f6_addr", pool.POOLPEB_AddrRd, 0);
        tick();
        chk("f6_fnh_after", fnh, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
